systolic_seq_ctrl: RTL and testbench

- Command sequencer between the RISC-V coprocessor command interface and the PE_ROW x PE_COL systolic array subsystem.
- Accepts one command at a time over a valid/ready handshake: load weights, or compute with loaded weights.
- Drives the array's din_data/PEmode/out_valid, waits for the array's finish pulses with a timeout, captures the result matrix and returns it over a valid/ready response channel.

---
 rtl/systolic_seq_ctrl_pkg.sv | 34 +++
 rtl/systolic_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and codes for the systolic array command sequencer:
// default geometry, PEmode codes, command ops, response errors, FSM states.
package systolic_seq_ctrl_pkg;

  localparam int PE_ROW_D  = 4;
  localparam int PE_COL_D  = 4;
  localparam int DWIDTH_D  = 16;
  localparam int TIMEOUT_D = 255;

  typedef enum logic [1:0] {
    PM_INIT = 2'b00,
    PM_WLOD = 2'b01,
    PM_DLOD = 2'b11
  } pemode_e;

  localparam logic [1:0] OP_LOADW   = 2'b00;
  localparam logic [1:0] OP_COMPUTE = 2'b01;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_NOW   = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_BADOP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_WWAIT = 3'd2,
    S_DLOAD = 3'd3,
    S_DWAIT = 3'd4,
    S_ABORT = 3'd5,
    S_RESP  = 3'd6
  } state_e;

endpackage

// File: rtl/systolic_seq_ctrl.sv
// Command sequencer between the coprocessor cmd/rsp channels and the
// systolic array. Ports:
//   clk, rst_n (sync, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_data   : command channel
//   rsp_valid/rsp_ready/rsp_data/rsp_err  : response channel
//   arr_din_data/arr_pemode/arr_out_valid : array drive
//   arr_result/arr_load_finish/arr_final_finish : array return
//   weights_loaded, busy                  : status
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int PE_ROW  = PE_ROW_D,
  parameter int PE_COL  = PE_COL_D,
  parameter int DWIDTH  = DWIDTH_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [PE_ROW*PE_COL*DWIDTH-1:0] cmd_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [PE_ROW*PE_COL*DWIDTH-1:0] rsp_data,
  output logic [1:0]                      rsp_err,
  output logic [PE_ROW*PE_COL*DWIDTH-1:0] arr_din_data,
  output logic [1:0]                      arr_pemode,
  output logic                            arr_out_valid,
  input  logic [PE_ROW*PE_COL*DWIDTH-1:0] arr_result,
  input  logic                            arr_load_finish,
  input  logic                            arr_final_finish,
  output logic                            weights_loaded,
  output logic                            busy
);

  localparam int MW = PE_ROW * PE_COL * DWIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          r_state;
  state_e          w_next;
  logic [CW-1:0]   r_cnt;
  logic [MW-1:0]   r_buf;
  logic [MW-1:0]   r_rsp_data;
  logic [1:0]      r_rsp_err;
  logic            r_wl;
  logic            w_acc;
  logic            w_tmo;
  pemode_e         w_pm;
  logic            w_ov;

  assign w_acc = cmd_valid && (r_state == S_IDLE);
  assign w_tmo = (r_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          unique case (1'b1)
            (cmd_op == OP_LOADW):   w_next = S_WLOAD;
            (cmd_op == OP_COMPUTE): w_next = r_wl ? S_DLOAD : S_RESP;
            default:                w_next = S_RESP;
          endcase
        end
      end
      S_WLOAD: w_next = S_WWAIT;
      S_WWAIT: begin
        if (arr_load_finish) w_next = S_RESP;
        else if (w_tmo)      w_next = S_ABORT;
      end
      S_DLOAD: w_next = S_DWAIT;
      S_DWAIT: begin
        if (arr_final_finish) w_next = S_RESP;
        else if (w_tmo)       w_next = S_ABORT;
      end
      S_ABORT: w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Array controls depend on state only, never on cmd inputs.
  always_comb begin
    w_pm = PM_INIT;
    w_ov = 1'b0;
    unique case (1'b1)
      (r_state == S_WLOAD): begin
        w_pm = PM_WLOD;
        w_ov = 1'b1;
      end
      (r_state == S_WWAIT): w_ov = 1'b1;
      (r_state == S_DLOAD),
      (r_state == S_DWAIT): begin
        w_pm = PM_DLOD;
        w_ov = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_buf      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= ERR_OK;
      r_wl       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_buf      <= cmd_data;
            r_rsp_data <= '0;
            unique case (1'b1)
              (cmd_op == OP_LOADW):   r_rsp_err <= ERR_OK;
              (cmd_op == OP_COMPUTE): r_rsp_err <= r_wl ? ERR_OK : ERR_NOW;
              default:                r_rsp_err <= ERR_BADOP;
            endcase
          end
        end
        S_WLOAD, S_DLOAD: r_cnt <= '0;
        S_WWAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (arr_load_finish) begin
            r_wl      <= 1'b1;
            r_rsp_err <= ERR_OK;
          end else if (w_tmo) begin
            // A failed load leaves the array weights undefined.
            r_wl      <= 1'b0;
            r_rsp_err <= ERR_TMO;
          end
        end
        S_DWAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (arr_final_finish) begin
            r_rsp_data <= arr_result;
            r_rsp_err  <= ERR_OK;
          end else if (w_tmo) begin
            r_rsp_err <= ERR_TMO;
          end
        end
        S_ABORT: r_rsp_data <= '0;
        default: ;
      endcase
    end
  end

  assign cmd_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign rsp_valid      = (r_state == S_RESP);
  assign rsp_data       = r_rsp_data;
  assign rsp_err        = r_rsp_err;
  assign arr_din_data   = r_buf;
  assign arr_pemode     = w_pm;
  assign arr_out_valid  = w_ov;
  assign weights_loaded = r_wl;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: directed and random commands
// against a transaction-level model of the sequencer and array.
module tb_systolic_seq_ctrl;

  localparam int PR  = 4;
  localparam int PC  = 4;
  localparam int DW  = 16;
  localparam int TMO = 255;
  localparam int MW  = PR * PC * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [MW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [MW-1:0] rsp_data;
  logic [1:0]    rsp_err;
  logic [MW-1:0] arr_din_data;
  logic [1:0]    arr_pemode;
  logic          arr_out_valid;
  logic [MW-1:0] arr_result;
  logic          arr_load_finish;
  logic          arr_final_finish;
  logic          weights_loaded;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;
  bit m_wl  = 1'b0;

  systolic_seq_ctrl #(
    .PE_ROW(PR), .PE_COL(PC), .DWIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .arr_din_data(arr_din_data), .arr_pemode(arr_pemode),
    .arr_out_valid(arr_out_valid), .arr_result(arr_result),
    .arr_load_finish(arr_load_finish),
    .arr_final_finish(arr_final_finish),
    .weights_loaded(weights_loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MW-1:0] obs,
                     input logic [MW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] rnd_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // Element (r,c); row 0 column 0 occupies the top bits.
  function automatic logic [MW-1:0] mat(input int kind);
    logic [MW-1:0] m;
    int idx;
    m = '0;
    for (int r = 0; r < PR; r++)
      for (int c = 0; c < PC; c++) begin
        idx = PR * PC - 1 - (r * PC + c);
        if (kind == 0) m[idx*DW +: DW] = (r == c) ? 16'd1 : 16'd0;
        else           m[idx*DW +: DW] = 16'(r * PC + c + 1);
      end
    return m;
  endfunction

  // j = wait-cycle index at which the array pulses finish; -1 = never.
  task automatic run_cmd(input logic [1:0] op, input logic [MW-1:0] d,
                         input int j, input int hold);
    logic [MW-1:0] ed;
    logic [1:0]    ee;
    bit w, c, tmo;
    int k;
    w   = (op == 2'b00);
    c   = (op == 2'b01) && m_wl;
    ed  = '0;
    tmo = 1'b0;
    if (w || c)          ee = 2'b00;
    else if (op == 2'b01) ee = 2'b01;
    else                 ee = 2'b11;

    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = rnd_mat();
    if (w || c) begin
      chk("load_pm", arr_pemode, w ? 1 : 3);
      chk("load_ov", arr_out_valid, 1);
      chk("load_din", arr_din_data, d);
      k = 0;
      forever begin
        @(negedge clk);
        chk("wait_pm", arr_pemode, w ? 0 : 3);
        chk("wait_ov", arr_out_valid, 1);
        chk("wait_din", arr_din_data, d);
        chk("wait_rv", rsp_valid, 0);
        arr_result = rnd_mat();
        if (k == j) begin
          if (w) arr_load_finish = 1'b1;
          else begin
            arr_final_finish = 1'b1;
            ed = arr_result;
          end
          break;
        end
        if (k == TMO) begin
          tmo = 1'b1;
          break;
        end
        k++;
      end
      @(negedge clk);
      arr_load_finish  = 1'b0;
      arr_final_finish = 1'b0;
      if (tmo) begin
        ee = 2'b10;
        ed = '0;
        chk("abort_pm", arr_pemode, 0);
        chk("abort_ov", arr_out_valid, 0);
        chk("abort_rv", rsp_valid, 0);
        chk("abort_busy", busy, 1);
        if (w) m_wl = 1'b0;
        @(negedge clk);
      end else if (w) begin
        m_wl = 1'b1;
      end
    end else begin
      chk("err_ov", arr_out_valid, 0);
    end

    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, ee);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_cmd_ready", cmd_ready, 0);
    chk("rsp_ov", arr_out_valid, 0);
    chk("rsp_pm", arr_pemode, 0);
    chk("rsp_wl", weights_loaded, m_wl);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rv", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_err", rsp_err, ee);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rv", rsp_valid, 0);
    chk("done_ready", cmd_ready, 1);
    chk("done_busy", busy, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rv", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_pm", arr_pemode, 0);
    chk("rst_ov", arr_out_valid, 0);
    chk("rst_din", arr_din_data, 0);
    chk("rst_wl", weights_loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
  endtask

  initial begin
    logic [1:0] op;
    int j;
    rst_n            = 1'b0;
    cmd_valid        = 1'b0;
    cmd_op           = 2'b00;
    cmd_data         = '0;
    rsp_ready        = 1'b0;
    arr_result       = '0;
    arr_load_finish  = 1'b0;
    arr_final_finish = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // Compute before any weights, then bad op.
    run_cmd(2'b01, mat(1), 0, 0);
    run_cmd(2'b11, rnd_mat(), 0, 1);

    // Identity load, finish 3 cycles after WLOAD, then compute.
    run_cmd(2'b00, mat(0), 2, 0);
    run_cmd(2'b01, mat(1), 4, 10);

    // Compute timeout keeps weights; finish on the last wait cycle wins.
    run_cmd(2'b01, rnd_mat(), -1, 0);
    run_cmd(2'b01, rnd_mat(), TMO, 0);
    run_cmd(2'b00, rnd_mat(), TMO, 0);

    // Load timeout drops weights.
    run_cmd(2'b00, rnd_mat(), -1, 0);
    run_cmd(2'b01, rnd_mat(), 1, 0);

    for (int n = 0; n < 20; n++) begin
      op = 2'($urandom_range(0, 3));
      j  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8));
      run_cmd(op, rnd_mat(), j, int'($urandom_range(0, 3)));
    end

    // Reset in DWAIT abandons the command.
    run_cmd(2'b00, mat(0), 0, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = mat(1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_pm", arr_pemode, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    m_wl  = 1'b0;
    arr_final_finish = 1'b1;
    arr_load_finish  = 1'b1;
    @(negedge clk);
    arr_final_finish = 1'b0;
    arr_load_finish  = 1'b0;
    chk("stray_rv", rsp_valid, 0);
    chk("stray_wl", weights_loaded, 0);
    repeat (2) @(negedge clk);
    chk("stray_rv2", rsp_valid, 0);
    chk("stray_busy", busy, 0);
    run_cmd(2'b10, rnd_mat(), 0, 0);
    run_cmd(2'b01, rnd_mat(), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
